// File: rtl/rvvi_serializer_pkg.sv
// ---------------------------------------------------------------------------
// rvvi_serializer_pkg
// Shared types and helpers for the RVVI retirement serializer.
//
// rvvi_entry_t is one buffered retirement. Field widths are fixed at the
// largest supported values: ILEN and XLEN up to 64, hart and retire index up
// to 8 bits. Modules zero-extend into the fields and slice back out, so a
// single struct type serves every parameterisation of the serializer.
//
// A trace slot s maps to hart s / RETIRE and to retire index s % RETIRE.
// ---------------------------------------------------------------------------
package rvvi_serializer_pkg;

    localparam int RVVI_ILEN_MAX = 64;
    localparam int RVVI_XLEN_MAX = 64;
    localparam int RVVI_IDX_W    = 8;
    localparam int RVVI_SEQ_W    = 64;

    typedef struct packed {
        logic [RVVI_ILEN_MAX-1:0] insn;
        logic [RVVI_XLEN_MAX-1:0] pc;
        logic                     trap;
        logic [RVVI_IDX_W-1:0]    hart;
        logic [RVVI_IDX_W-1:0]    ret;
        logic [RVVI_SEQ_W-1:0]    seq;
    } rvvi_entry_t;

    function automatic int slot_hart(input int slot, input int retire);
        return slot / retire;
    endfunction

    function automatic int slot_ret(input int slot, input int retire);
        return slot % retire;
    endfunction

endpackage

// File: rtl/rvvi_serial_fifo.sv
// ---------------------------------------------------------------------------
// rvvi_serial_fifo
// Multi-write, single-read, show-ahead circular buffer of rvvi_entry_t.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-high reset; empties the buffer
//   wr_cnt     in   number of entries to write this cycle, taken from
//                   wr_data[0 .. wr_cnt-1]; the writer must keep wr_cnt at or
//                   below free_cnt
//   wr_data    in   NWR compacted entries
//   rd_ready   in   consumer accepts the head; a pop happens when non-empty
//   head       out  head entry, all zeros when empty
//   occupancy  out  number of stored entries, 0..DEPTH
//   free_cnt   out  DEPTH - occupancy + pop; a same-edge pop frees its slot
//
// DEPTH must be a power of two, at least 2 and at least NWR.
// ---------------------------------------------------------------------------
module rvvi_serial_fifo
    import rvvi_serializer_pkg::*;
#(
    parameter int NWR   = 1,
    parameter int DEPTH = 16,
    localparam int WCW  = $clog2(NWR + 1),
    localparam int PW   = $clog2(DEPTH),
    localparam int OW   = PW + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WCW-1:0]            wr_cnt,
    input  rvvi_entry_t [NWR-1:0]     wr_data,
    input  logic                      rd_ready,
    output rvvi_entry_t               head,
    output logic [OW-1:0]             occupancy,
    output logic [OW-1:0]             free_cnt
);

    rvvi_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] occ_q;
    logic          pop;

    assign pop       = (occ_q != '0) && rd_ready;
    assign free_cnt  = OW'(DEPTH) - occ_q + OW'(pop);
    assign occupancy = occ_q;
    // Gating on empty keeps the outputs at zero after reset even though the
    // storage itself is never cleared.
    assign head      = (occ_q != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NWR; i++) begin
            if (WCW'(i) < wr_cnt) begin
                mem[wr_ptr + PW'(i)] <= wr_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr_cnt);
            rd_ptr <= rd_ptr + PW'(pop);
            occ_q  <= occ_q + OW'(wr_cnt) - OW'(pop);
        end
    end

endmodule

// File: rtl/rvvi_retire_serializer.sv
// ---------------------------------------------------------------------------
// rvvi_retire_serializer
// Buffers a full RVVI retirement trace of up to NHART*RETIRE instructions per
// cycle and replays it one instruction per beat, in retirement order, over a
// valid/ready stream that feeds the functional-coverage sampler.
//
// Ports:
//   clk, reset            trace clock, asynchronous active-high reset
//   in_valid/insn/pc/trap per-slot trace inputs, slot s = hart*RETIRE + ret
//   out_valid/out_ready   output handshake; a beat pops on valid && ready
//   out_insn/pc/trap      head instruction, PC and trap flag
//   out_hart/out_ret      source hart and retire index of the head
//   out_seq               64-bit sequence number of the head, from 0
//   overflow              sticky: at least one valid slot was dropped
//   occupancy             entries currently stored
//
// Optional build macro RVVI_SERIALIZER_STATS_EN adds:
//   stat_retired (64)     accepted slots
//   stat_dropped (32)     dropped slots, saturating
//
// Outputs come from storage only; nothing on in_* reaches out_* in the same
// cycle. When the trace offers more valid slots than there is free space, the
// lowest-indexed valid slots win and the rest are dropped without consuming
// sequence numbers.
// ---------------------------------------------------------------------------
module rvvi_retire_serializer
    import rvvi_serializer_pkg::*;
#(
    parameter int ILEN   = 32,
    parameter int XLEN   = 64,
    parameter int NHART  = 1,
    parameter int RETIRE = 1,
    parameter int DEPTH  = 16,
    localparam int NSLOT = NHART * RETIRE,
    localparam int HW    = (NHART > 1) ? $clog2(NHART) : 1,
    localparam int RW    = (RETIRE > 1) ? $clog2(RETIRE) : 1,
    localparam int OW    = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSLOT-1:0]        in_valid,
    input  logic [NSLOT*ILEN-1:0]   in_insn,
    input  logic [NSLOT*XLEN-1:0]   in_pc,
    input  logic [NSLOT-1:0]        in_trap,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ILEN-1:0]         out_insn,
    output logic [XLEN-1:0]         out_pc,
    output logic                    out_trap,
    output logic [HW-1:0]           out_hart,
    output logic [RW-1:0]           out_ret,
    output logic [63:0]             out_seq,
    output logic                    overflow,
    output logic [OW-1:0]           occupancy
`ifdef RVVI_SERIALIZER_STATS_EN
   ,output logic [63:0]             stat_retired,
    output logic [31:0]             stat_dropped
`endif
);

    localparam int WCW = $clog2(NSLOT + 1);
    localparam int CW  = (WCW > OW) ? WCW : OW;

    rvvi_entry_t [NSLOT-1:0] wr_data;
    rvvi_entry_t             head;
    logic [WCW-1:0]          wr_cnt;
    logic [OW-1:0]           free_cnt;
    logic [CW-1:0]           free_c;
    logic [CW-1:0]           valid_cnt;
    logic [CW-1:0]           acc_cnt;
    logic                    drop;
    logic [63:0]             seq_q;
    logic                    overflow_q;

    assign free_c = CW'(free_cnt);

    // Compaction: the k-th valid slot (counting from slot 0) lands in write
    // lane k, provided k is still below the free space.
    always_comb begin
        wr_data   = '0;
        valid_cnt = '0;
        for (int s = 0; s < NSLOT; s++) begin
            if (in_valid[s]) begin
                for (int j = 0; j < NSLOT; j++) begin
                    if ((valid_cnt == CW'(j)) && (valid_cnt < free_c)) begin
                        wr_data[j].insn = RVVI_ILEN_MAX'(in_insn[s*ILEN +: ILEN]);
                        wr_data[j].pc   = RVVI_XLEN_MAX'(in_pc[s*XLEN +: XLEN]);
                        wr_data[j].trap = in_trap[s];
                        wr_data[j].hart = RVVI_IDX_W'(slot_hart(s, RETIRE));
                        wr_data[j].ret  = RVVI_IDX_W'(slot_ret(s, RETIRE));
                        wr_data[j].seq  = seq_q + 64'(j);
                    end
                end
                valid_cnt = valid_cnt + CW'(1);
            end
        end
    end

    assign acc_cnt = (valid_cnt < free_c) ? valid_cnt : free_c;
    assign wr_cnt  = WCW'(acc_cnt);
    assign drop    = (valid_cnt != acc_cnt);

    rvvi_serial_fifo #(
        .NWR   (NSLOT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_cnt    (wr_cnt),
        .wr_data   (wr_data),
        .rd_ready  (out_ready),
        .head      (head),
        .occupancy (occupancy),
        .free_cnt  (free_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            seq_q      <= seq_q + 64'(acc_cnt);
            overflow_q <= overflow_q | drop;
        end
    end

`ifdef RVVI_SERIALIZER_STATS_EN
    logic [CW-1:0] drop_cnt;
    logic [32:0]   drop_sum;

    assign drop_cnt = valid_cnt - acc_cnt;
    assign drop_sum = {1'b0, stat_dropped} + 33'(drop_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_retired <= '0;
            stat_dropped <= '0;
        end else begin
            stat_retired <= stat_retired + 64'(acc_cnt);
            stat_dropped <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end
`endif

    assign out_valid = (occupancy != '0);
    assign out_insn  = head.insn[ILEN-1:0];
    assign out_pc    = head.pc[XLEN-1:0];
    assign out_trap  = head.trap;
    assign out_hart  = head.hart[HW-1:0];
    assign out_ret   = head.ret[RW-1:0];
    assign out_seq   = head.seq;
    assign overflow  = overflow_q;

    // The struct fields are wider than this parameterisation needs.
    logic unused_head_bits;
    assign unused_head_bits = ^head;

endmodule

// File: tb/tb_rvvi_retire_serializer.sv
// ---------------------------------------------------------------------------
// tb_rvvi_retire_serializer
// Directed bench for rvvi_retire_serializer. Instance u_a is single-issue
// (NHART=1, RETIRE=1, DEPTH=16); instance u_b is two harts by two retires
// with a 4-entry buffer. Build with RVVI_SERIALIZER_STATS_EN defined to also
// cover the statistics counters.
// ---------------------------------------------------------------------------
module tb_rvvi_retire_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic [0:0]  a_in_valid;
    logic [31:0] a_in_insn;
    logic [63:0] a_in_pc;
    logic [0:0]  a_in_trap;
    logic        a_out_ready;
    logic        a_out_valid;
    logic [31:0] a_out_insn;
    logic [63:0] a_out_pc;
    logic        a_out_trap;
    logic [0:0]  a_out_hart;
    logic [0:0]  a_out_ret;
    logic [63:0] a_out_seq;
    logic        a_overflow;
    logic [4:0]  a_occupancy;

    logic [3:0]   b_in_valid;
    logic [127:0] b_in_insn;
    logic [255:0] b_in_pc;
    logic [3:0]   b_in_trap;
    logic         b_out_ready;
    logic         b_out_valid;
    logic [31:0]  b_out_insn;
    logic [63:0]  b_out_pc;
    logic         b_out_trap;
    logic [0:0]   b_out_hart;
    logic [0:0]   b_out_ret;
    logic [63:0]  b_out_seq;
    logic         b_overflow;
    logic [2:0]   b_occupancy;

`ifdef RVVI_SERIALIZER_STATS_EN
    logic [63:0] a_stat_retired;
    logic [31:0] a_stat_dropped;
    logic [63:0] b_stat_retired;
    logic [31:0] b_stat_dropped;
`endif

    rvvi_retire_serializer #(
        .ILEN(32), .XLEN(64), .NHART(1), .RETIRE(1), .DEPTH(16)
    ) u_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_insn(a_in_insn), .in_pc(a_in_pc), .in_trap(a_in_trap),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_insn(a_out_insn), .out_pc(a_out_pc), .out_trap(a_out_trap),
        .out_hart(a_out_hart), .out_ret(a_out_ret), .out_seq(a_out_seq),
        .overflow(a_overflow), .occupancy(a_occupancy)
`ifdef RVVI_SERIALIZER_STATS_EN
       ,.stat_retired(a_stat_retired), .stat_dropped(a_stat_dropped)
`endif
    );

    rvvi_retire_serializer #(
        .ILEN(32), .XLEN(64), .NHART(2), .RETIRE(2), .DEPTH(4)
    ) u_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_insn(b_in_insn), .in_pc(b_in_pc), .in_trap(b_in_trap),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_insn(b_out_insn), .out_pc(b_out_pc), .out_trap(b_out_trap),
        .out_hart(b_out_hart), .out_ret(b_out_ret), .out_seq(b_out_seq),
        .overflow(b_overflow), .occupancy(b_occupancy)
`ifdef RVVI_SERIALIZER_STATS_EN
       ,.stat_retired(b_stat_retired), .stat_dropped(b_stat_dropped)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_in_valid  = '0; a_in_insn = '0; a_in_pc = '0; a_in_trap = '0; a_out_ready = 1'b0;
        b_in_valid  = '0; b_in_insn = '0; b_in_pc = '0; b_in_trap = '0; b_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        reset = 1'b0;
    endtask

    task automatic set_b_slot(input int s, input logic [31:0] insn,
                              input logic [63:0] pc, input logic trap);
        b_in_insn[s*32 +: 32] = insn;
        b_in_pc[s*64 +: 64]   = pc;
        b_in_trap[s]          = trap;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        checks++;
        if ({a_out_valid, a_occupancy, a_overflow, a_out_seq, a_out_insn, a_out_pc} !== '0) begin
            errors++;
            $display("FAIL reset_a: got valid=%0b occ=%0d ovf=%0b seq=%0d insn=%h pc=%h, expected all zero",
                     a_out_valid, a_occupancy, a_overflow, a_out_seq, a_out_insn, a_out_pc);
        end
        checks++;
        if ({b_out_valid, b_occupancy, b_overflow, b_out_seq, b_out_hart, b_out_ret, b_out_trap} !== '0) begin
            errors++;
            $display("FAIL reset_b: got valid=%0b occ=%0d ovf=%0b seq=%0d hart=%0d ret=%0d trap=%0b, expected all zero",
                     b_out_valid, b_occupancy, b_overflow, b_out_seq, b_out_hart, b_out_ret, b_out_trap);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_issue();
        logic [31:0] insns [3];
        logic [63:0] pc;
        insns = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
        do_reset();
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 64'h8000_0000 + 64'(4 * i);
            a_in_valid = 1'b1;
            a_in_insn  = insns[i];
            a_in_pc    = pc;
            checks++;
            if (a_out_valid !== (i != 0)) begin
                errors++;
                $display("FAIL single_pre_edge_valid[%0d]: got %0b expected %0b", i, a_out_valid, (i != 0));
            end
            step();
            checks++;
            if ({a_out_valid, a_out_insn, a_out_pc, a_out_seq} !== {1'b1, insns[i], pc, 64'(i)}) begin
                errors++;
                $display("FAIL single_beat[%0d]: got valid=%0b insn=%h pc=%h seq=%0d expected 1 %h %h %0d",
                         i, a_out_valid, a_out_insn, a_out_pc, a_out_seq, insns[i], pc, i);
            end
            checks++;
            if (a_occupancy !== 5'd1) begin
                errors++;
                $display("FAIL single_occ[%0d]: got %0d expected 1", i, a_occupancy);
            end
        end
        a_in_valid = 1'b0;
        step();
        checks++;
        if ({a_out_valid, a_occupancy, a_overflow} !== 7'b0) begin
            errors++;
            $display("FAIL single_drain: got valid=%0b occ=%0d ovf=%0b expected 0 0 0",
                     a_out_valid, a_occupancy, a_overflow);
        end
    endtask

    task automatic test_multi_slot();
        int exp_slot [3];
        int exp_hart [3];
        int exp_ret  [3];
        exp_slot = '{0, 1, 3};
        exp_hart = '{0, 0, 1};
        exp_ret  = '{0, 1, 1};
        do_reset();
        b_out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            set_b_slot(s, 32'hA0 + 32'(s), 64'h2000 + 64'(4 * s), (s == 3));
        end
        b_in_valid = 4'b1011;
        step();
        b_in_valid = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({b_out_valid, b_occupancy, b_out_insn, b_out_pc, b_out_seq} !==
                {1'b1, 3'(3 - k), 32'hA0 + 32'(exp_slot[k]), 64'h2000 + 64'(4 * exp_slot[k]), 64'(k)}) begin
                errors++;
                $display("FAIL multi_beat[%0d]: got valid=%0b occ=%0d insn=%h pc=%h seq=%0d expected 1 %0d %h %h %0d",
                         k, b_out_valid, b_occupancy, b_out_insn, b_out_pc, b_out_seq,
                         3 - k, 32'hA0 + exp_slot[k], 64'h2000 + 4 * exp_slot[k], k);
            end
            checks++;
            if ({b_out_hart, b_out_ret, b_out_trap} !== {1'(exp_hart[k]), 1'(exp_ret[k]), 1'(exp_slot[k] == 3)}) begin
                errors++;
                $display("FAIL multi_src[%0d]: got hart=%0d ret=%0d trap=%0b expected %0d %0d %0b",
                         k, b_out_hart, b_out_ret, b_out_trap, exp_hart[k], exp_ret[k], (exp_slot[k] == 3));
            end
            step();
        end
        checks++;
        if (b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_drain: got valid=%0b expected 0", b_out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        b_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_in_valid = 4'b0001;
            set_b_slot(0, 32'h100 + 32'(i), 64'h3000 + 64'(4 * i), 1'b0);
            step();
            checks++;
            if ({b_occupancy, b_overflow, b_out_insn, b_out_seq} !==
                {3'((i < 4) ? i + 1 : 4), 1'(i == 4), 32'h100, 64'd0}) begin
                errors++;
                $display("FAIL bp_fill[%0d]: got occ=%0d ovf=%0b head=%h seq=%0d expected %0d %0b 100 0",
                         i, b_occupancy, b_overflow, b_out_insn, b_out_seq, (i < 4) ? i + 1 : 4, (i == 4));
            end
        end
        b_in_valid = 4'b0000;
`ifdef RVVI_SERIALIZER_STATS_EN
        checks++;
        if ({b_stat_retired, b_stat_dropped} !== {64'd4, 32'd1}) begin
            errors++;
            $display("FAIL bp_stats: got retired=%0d dropped=%0d expected 4 1", b_stat_retired, b_stat_dropped);
        end
`endif
        b_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({b_out_valid, b_out_seq, b_out_insn} !== {1'b1, 64'(k), 32'h100 + 32'(k)}) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got valid=%0b seq=%0d insn=%h expected 1 %0d %h",
                         k, b_out_valid, b_out_seq, b_out_insn, k, 32'h100 + k);
            end
            step();
        end
        checks++;
        if ({b_out_valid, b_overflow, b_occupancy} !== {1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL bp_end: got valid=%0b ovf=%0b occ=%0d expected 0 1 0", b_out_valid, b_overflow, b_occupancy);
        end
    endtask

    task automatic test_pop_at_full();
        do_reset();
        b_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 4'b0001;
            set_b_slot(0, 32'h200 + 32'(i), 64'h4000 + 64'(4 * i), 1'b0);
            step();
        end
        checks++;
        if ({b_occupancy, b_overflow} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL full_fill: got occ=%0d ovf=%0b expected 4 0", b_occupancy, b_overflow);
        end
        b_out_ready = 1'b1;
        b_in_valid  = 4'b0001;
        set_b_slot(0, 32'h204, 64'h4010, 1'b0);
        step();
        b_in_valid = 4'b0000;
        checks++;
        if ({b_occupancy, b_overflow, b_out_seq, b_out_insn} !== {3'd4, 1'b0, 64'd1, 32'h201}) begin
            errors++;
            $display("FAIL full_simul_pop: got occ=%0d ovf=%0b seq=%0d insn=%h expected 4 0 1 201",
                     b_occupancy, b_overflow, b_out_seq, b_out_insn);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({b_out_valid, b_out_seq, b_out_insn} !== {1'b1, 64'(k + 1), 32'h201 + 32'(k)}) begin
                errors++;
                $display("FAIL full_drain[%0d]: got valid=%0b seq=%0d insn=%h expected 1 %0d %h",
                         k, b_out_valid, b_out_seq, b_out_insn, k + 1, 32'h201 + k);
            end
            step();
        end
        checks++;
        if ({b_out_valid, b_overflow} !== 2'b00) begin
            errors++;
            $display("FAIL full_end: got valid=%0b ovf=%0b expected 0 0", b_out_valid, b_overflow);
        end
    endtask

    task automatic test_partial_accept();
        logic [31:0] exp_insn [4];
        int          exp_hart [4];
        int          exp_ret  [4];
        exp_insn = '{32'h300, 32'h302, 32'h311, 32'h312};
        exp_hart = '{0, 1, 0, 1};
        exp_ret  = '{0, 0, 1, 0};
        do_reset();
        b_out_ready = 1'b0;
        for (int s = 0; s < 4; s++) set_b_slot(s, 32'h300 + 32'(s), 64'h5000 + 64'(s), 1'b0);
        b_in_valid = 4'b0101;
        step();
        checks++;
        if ({b_occupancy, b_overflow} !== {3'd2, 1'b0}) begin
            errors++;
            $display("FAIL partial_first: got occ=%0d ovf=%0b expected 2 0", b_occupancy, b_overflow);
        end
        for (int s = 0; s < 4; s++) set_b_slot(s, 32'h310 + 32'(s), 64'h5100 + 64'(s), 1'b0);
        b_in_valid = 4'b1110;
        step();
        b_in_valid = 4'b0000;
        checks++;
        if ({b_occupancy, b_overflow} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL partial_second: got occ=%0d ovf=%0b expected 4 1", b_occupancy, b_overflow);
        end
        b_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({b_out_valid, b_out_seq, b_out_insn, b_out_hart, b_out_ret} !==
                {1'b1, 64'(k), exp_insn[k], 1'(exp_hart[k]), 1'(exp_ret[k])}) begin
                errors++;
                $display("FAIL partial_drain[%0d]: got valid=%0b seq=%0d insn=%h hart=%0d ret=%0d expected 1 %0d %h %0d %0d",
                         k, b_out_valid, b_out_seq, b_out_insn, b_out_hart, b_out_ret,
                         k, exp_insn[k], exp_hart[k], exp_ret[k]);
            end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_insn  = 32'h400 + 32'(i);
            a_in_pc    = 64'h6000 + 64'(4 * i);
            step();
        end
        a_in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_occupancy} !== {1'b1, 5'd3}) begin
            errors++;
            $display("FAIL mid_fill: got valid=%0b occ=%0d expected 1 3", a_out_valid, a_occupancy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({a_out_valid, a_occupancy} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL mid_async_clear: got valid=%0b occ=%0d expected 0 0", a_out_valid, a_occupancy);
        end
        step();
        reset       = 1'b0;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_insn   = 32'h55;
        a_in_pc     = 64'h7000;
        step();
        a_in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_out_seq, a_out_insn, a_occupancy} !== {1'b1, 64'd0, 32'h55, 5'd1}) begin
            errors++;
            $display("FAIL mid_after_release: got valid=%0b seq=%0d insn=%h occ=%0d expected 1 0 55 1",
                     a_out_valid, a_out_seq, a_out_insn, a_occupancy);
        end
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_drain: got valid=%0b expected 0", a_out_valid);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_issue();
        test_multi_slot();
        test_backpressure();
        test_pop_at_full();
        test_partial_accept();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rvvi_retire_serializer.md
Name: rvvi_retire_serializer

Overview:
- Sits directly upstream of the functional-coverage sampler.
- Accepts the full RVVI retirement trace for a cycle: up to NHART×RETIRE retired instructions.
- Buffers them in a FIFO and emits them one per cycle, in retirement order, over a valid/ready stream.
- The sampler can then call its sample function once per output beat, so multi-hart and multi-retire traces no longer drop instructions.

Parameters:
- ILEN, 32, instruction width
- XLEN, 64, PC width
- NHART, 1, number of harts
- RETIRE, 1, max retirements per hart per cycle
- DEPTH, 16, FIFO entries; power of two, and must be ≥ NHART×RETIRE

Ports:
- clk  in  1  RVVI trace clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  NHART*RETIRE  slot valid; slot s = hart*RETIRE + ret
- in_insn  in  NHART*RETIRE*ILEN  instruction per slot, slot s at bits [s*ILEN +: ILEN]
- in_pc  in  NHART*RETIRE*XLEN  pc_rdata per slot
- in_trap  in  NHART*RETIRE  trap flag per slot
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head this cycle
- out_insn  out  ILEN  head instruction
- out_pc  out  XLEN  head PC
- out_trap  out  1  head trap flag
- out_hart  out  HW=max(1,$clog2(NHART))  source hart of head
- out_ret  out  RW=max(1,$clog2(RETIRE))  source retire index of head
- out_seq  out  64  running sequence number of head, starting at 0
- overflow  out  1  sticky: at least one valid slot was dropped
- occupancy  out  $clog2(DEPTH)+1  entries currently stored

Behaviour:
- Reset (async assert, sync release): all outputs are 0, and pointers, occupancy, overflow and the sequence counter clear.
  - Reset asserted mid-stream discards all buffered entries.
  - The first beat after reset has out_seq=0.
- Enqueue order within a cycle:
  - Valid slots are written in ascending slot index: hart-major, then retire index.
  - Invalid slots are skipped and consume no entry.
- Pop: occurs when out_valid && out_ready at the rising edge.
- Show-ahead outputs: out_* always reflect the FIFO head, driven from storage with no combinational path from in_*.
  - An entry enqueued at edge N is visible on out_* after edge N, giving 1-cycle latency into an empty FIFO.
  - out_valid = (occupancy != 0).
- Free space = DEPTH − occupancy + (pop this cycle ? 1 : 0); a simultaneous pop frees its slot for the same edge.
- Full/overflow handling:
  - If the number of valid slots exceeds free space, the first `free` valid slots in order are enqueued and the rest are dropped.
  - On any drop, overflow sets and stays set until reset.
  - Dropped slots do not consume sequence numbers.
- Sequence numbers:
  - Assigned at enqueue; each accepted slot takes the next value.
  - Wrap modulo 2^64.
- Occupancy: next = occupancy + accepted − pop. Always within [0, DEPTH].
- out_ready deasserted: the head is held stable; out_* do not change until popped.
- Pointers wrap modulo DEPTH.
- No reordering across cycles; the output is strict FIFO.

Optional Feature:
- Macro: RVVI_SERIALIZER_STATS_EN.
- When defined, two extra outputs are added:
  - stat_retired (64): count of accepted slots.
  - stat_dropped (32): count of dropped slots, saturating at all-ones.
  - Both reset to 0 and update at the same edge as the enqueue.
- When undefined, these ports and counters do not exist, and overflow is the only loss indication.

Decomposition:
- Shared package rvvi_serializer_pkg:
  - typedef rvvi_entry_t as a packed struct {insn, pc, trap, hart, ret, seq}, parameterized via localparams.
  - Functions for slot→hart/ret index mapping.
- Sub-module rvvi_serial_fifo:
  - Multi-write (up to NHART×RETIRE per cycle), single-read, show-ahead circular buffer.
  - Reports free-space count.
  - The top level handles slot compaction, sequence numbering and overflow.

Test Plan:
1. Single-issue, NHART=1, RETIRE=1, out_ready=1: three consecutive valid cycles (insn 0x00000013, 0x00100093, 0x00200113) → out_valid rises one cycle after each, out_seq 0,1,2, occupancy never exceeds 1.
2. NHART=2, RETIRE=2, in_valid=4'b1011 in one cycle, out_ready=1 → three beats in slot order 0,1,3, with (hart,ret) = (0,0), (0,1), (1,1) and seq 0,1,2.
3. Backpressure: DEPTH=4, out_ready=0, 5 single valid cycles → occupancy reaches 4, fifth slot dropped, overflow=1. Releasing out_ready yields exactly 4 beats with seq 0–3.
4. Simultaneous pop at full: occupancy=4, out_ready=1, one valid slot arriving → accepted with no overflow, occupancy stays 4.
5. Reset mid-stream: assert reset with occupancy=3 → out_valid=0 and occupancy=0 immediately (async). After release, next input produces out_seq=0.
6. RVVI_SERIALIZER_STATS_EN defined, scenario 3 → stat_retired=4, stat_dropped=1.
